ex2_fpu_sequencer: RTL and testbench

//  Sequences multi-cycle FPU ops in issue slot 2 of the VLIW EX stage.

---
 rtl/ex2_seq_pkg.sv | 39 +++
 rtl/fwd_kept_remap.sv | 24 ++
 rtl/ex2_fpu_sequencer.sv | 93 +++++++++
 tb/tb_ex2_fpu_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ex2_seq_pkg.sv
// Shared definitions for the slot-2 FPU sequencer: forward-select codes,
// FPU op encodings, the op latency table and the FSM state type.
package ex2_seq_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned FWD_W = 4;

    localparam logic [FWD_W-1:0] FWD_SRC = 4'b0000;
    localparam logic [FWD_W-1:0] FWD_M1  = 4'b0001;
    localparam logic [FWD_W-1:0] FWD_M2  = 4'b0010;
    localparam logic [FWD_W-1:0] FWD_W3  = 4'b0011;
    localparam logic [FWD_W-1:0] FWD_W4  = 4'b0100;
    localparam logic [FWD_W-1:0] FWD_K3  = 4'b0101;
    localparam logic [FWD_W-1:0] FWD_K1  = 4'b1000;
    localparam logic [FWD_W-1:0] FWD_K2  = 4'b1001;
    localparam logic [FWD_W-1:0] FWD_K4  = 4'b1010;

    localparam logic [OP_W-1:0] FOP_FADD  = 4'b0001;
    localparam logic [OP_W-1:0] FOP_FSUB  = 4'b0010;
    localparam logic [OP_W-1:0] FOP_FMUL  = 4'b0011;
    localparam logic [OP_W-1:0] FOP_FDIV  = 4'b0100;
    localparam logic [OP_W-1:0] FOP_FSQRT = 4'b0101;
    localparam logic [OP_W-1:0] FOP_FTOI  = 4'b0110;
    localparam logic [OP_W-1:0] FOP_ITOF  = 4'b0111;

    typedef enum logic [0:0] {StIdle, StBusy} seq_state_e;

    // Cycles until the result is valid; 0 means the op is combinational.
    function automatic logic [CNT_W-1:0] fpu_lat(input logic [OP_W-1:0] op);
        unique case (op)
            FOP_FADD, FOP_FSUB, FOP_FMUL: fpu_lat = 3'd2;
            FOP_FDIV, FOP_FSQRT:          fpu_lat = 3'd6;
            FOP_FTOI, FOP_ITOF:           fpu_lat = 3'd1;
            default:                      fpu_lat = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/fwd_kept_remap.sv
// Redirects M/W forward selects to the matching Kept register while an FPU op
// is in flight; all other codes, and everything when disabled, pass through.
module fwd_kept_remap
    import ex2_seq_pkg::*;
(
    input  logic             en_i,
    input  logic [FWD_W-1:0] sel_i,
    output logic [FWD_W-1:0] sel_o
);

    always_comb begin
        sel_o = sel_i;
        if (en_i) begin
            unique case (sel_i)
                FWD_M1:  sel_o = FWD_K1;
                FWD_M2:  sel_o = FWD_K2;
                FWD_W3:  sel_o = FWD_K3;
                FWD_W4:  sel_o = FWD_K4;
                default: sel_o = sel_i;
            endcase
        end
    end

endmodule

// File: rtl/ex2_fpu_sequencer.sv
// Slot-2 FPU sequencer: holds the E stage for multi-cycle FPU ops, pulses the
// Kept-register capture and remaps operand forwarding while the op runs.
module ex2_fpu_sequencer
    import ex2_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_valid,
    input  logic [4:0]       FPUControlE2,
    input  logic             flushE,
    input  logic [FWD_W-1:0] ForwardaE2_i,
    input  logic [FWD_W-1:0] ForwardbE2_i,
    output logic [FWD_W-1:0] ForwardaE2_o,
    output logic [FWD_W-1:0] ForwardbE2_o,
    output logic             stallE2,
    output logic             keep_en,
    output logic             fpu_done,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] op_lat;
    logic             fpu_sel;
    logic             accept;
    logic             done_busy;
    logic             remap_en;

    assign fpu_sel = FPUControlE2[0];
    assign op_lat  = fpu_lat(FPUControlE2[4:1]);

    // rstn gates the combinational outputs so they read idle during reset.
    assign accept = rstn & issue_valid & fpu_sel & (op_lat != '0) &
                    (state_q == StIdle) & ~flushE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_busy = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StBusy;
                    cnt_d   = op_lat - CNT_W'(1);
                end
            end
            StBusy: begin
                if (flushE) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    done_busy = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == StBusy);
    assign keep_en  = accept;
    assign stallE2  = accept | (rstn & busy & (cnt_q != '0));
    assign fpu_done = rstn & (done_busy | (issue_valid & fpu_sel & (op_lat == '0)));
    assign remap_en = rstn & busy;

    fwd_kept_remap u_remap_a (
        .en_i  (remap_en),
        .sel_i (ForwardaE2_i),
        .sel_o (ForwardaE2_o)
    );

    fwd_kept_remap u_remap_b (
        .en_i  (remap_en),
        .sel_i (ForwardbE2_i),
        .sel_o (ForwardbE2_o)
    );

endmodule

// File: tb/tb_ex2_fpu_sequencer.sv
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a timeline model of in-flight FPU ops.
module tb_ex2_fpu_sequencer;
    import ex2_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       issue_valid;
    logic [4:0] FPUControlE2;
    logic       flushE;
    logic [3:0] ForwardaE2_i, ForwardbE2_i, ForwardaE2_o, ForwardbE2_o;
    logic       stallE2, keep_en, fpu_done, busy;

    int compared = 0;
    int mismatched = 0;

    // Model: the op in flight was accepted at cycle start with latency mlat.
    bit infl = 1'b0;
    int start = 0;
    int mlat = 0;
    int cyc = 0;

    ex2_fpu_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .issue_valid  (issue_valid),
        .FPUControlE2 (FPUControlE2),
        .flushE       (flushE),
        .ForwardaE2_i (ForwardaE2_i),
        .ForwardbE2_i (ForwardbE2_i),
        .ForwardaE2_o (ForwardaE2_o),
        .ForwardbE2_o (ForwardbE2_o),
        .stallE2      (stallE2),
        .keep_en      (keep_en),
        .fpu_done     (fpu_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_lat(input logic [3:0] op);
        if (op == FOP_FADD || op == FOP_FSUB || op == FOP_FMUL) return 2;
        if (op == FOP_FDIV || op == FOP_FSQRT) return 6;
        if (op == FOP_FTOI || op == FOP_ITOF) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] ref_remap(input bit en, input logic [3:0] s);
        if (!en) return s;
        case (s)
            4'd1:    return 4'd8;
            4'd2:    return 4'd9;
            4'd3:    return 4'd5;
            4'd4:    return 4'd10;
            default: return s;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit iv, input logic [4:0] ctl, input bit fl,
                        input logic [3:0] fa, input logic [3:0] fb, input bit rs);
        int  l;
        bit  acc, done_exp, stall_exp;
        @(negedge clk);
        issue_valid  = iv;
        FPUControlE2 = ctl;
        flushE       = fl;
        ForwardaE2_i = fa;
        ForwardbE2_i = fb;
        rstn         = rs;
        #1;
        l         = ref_lat(ctl[4:1]);
        acc       = rs && iv && ctl[0] && l != 0 && !infl && !fl;
        done_exp  = rs && ((infl && cyc == start + mlat && !fl) || (iv && ctl[0] && l == 0));
        stall_exp = acc || (rs && infl && cyc < start + mlat);
        chk("stallE2", {3'b0, stallE2}, {3'b0, stall_exp});
        chk("keep_en", {3'b0, keep_en}, {3'b0, acc});
        chk("fpu_done", {3'b0, fpu_done}, {3'b0, done_exp});
        chk("fwd_a", ForwardaE2_o, ref_remap(rs && infl, fa));
        chk("fwd_b", ForwardbE2_o, ref_remap(rs && infl, fb));
        if (rs) chk("busy", {3'b0, busy}, {3'b0, infl});
        @(posedge clk);
        if (!rs) infl = 1'b0;
        else if (infl) begin
            if (fl || cyc == start + mlat) infl = 1'b0;
        end else if (acc) begin
            infl  = 1'b1;
            start = cyc;
            mlat  = l;
        end
        cyc++;
    endtask

    initial begin
        logic [4:0] c_fdiv, c_fadd, c_fmul, c_lat0;
        c_fdiv = {FOP_FDIV, 1'b1};
        c_fadd = {FOP_FADD, 1'b1};
        c_fmul = {FOP_FMUL, 1'b1};
        c_lat0 = {4'b1111, 1'b1};

        repeat (2) step(0, 5'd0, 0, 4'd1, 4'd2, 0);
        step(0, 5'd0, 0, 4'd1, 4'd2, 1);

        // fdiv with operand a forwarded from M1, held in E for its latency
        repeat (7) step(1, c_fdiv, 0, 4'd1, 4'd3, 1);
        step(0, 5'd0, 0, 4'd1, 4'd0, 1);

        // fadd with operand b from W4
        repeat (3) step(1, c_fadd, 0, 4'd2, 4'd4, 1);
        step(0, 5'd0, 0, 4'd0, 4'd4, 1);

        // combinational FPU op
        step(1, c_lat0, 0, 4'd1, 4'd1, 1);
        step(0, 5'd0, 0, 4'd1, 4'd1, 1);

        // fdiv flushed at T+3, fadd accepted at T+4
        repeat (3) step(1, c_fdiv, 0, 4'd3, 4'd4, 1);
        step(1, c_fdiv, 1, 4'd3, 4'd4, 1);
        repeat (3) step(1, c_fadd, 0, 4'd1, 4'd2, 1);

        // reset in the middle of an fdiv
        repeat (2) step(1, c_fdiv, 0, 4'd1, 4'd2, 1);
        step(1, c_fdiv, 0, 4'd1, 4'd2, 0);
        repeat (2) step(0, 5'd0, 0, 4'd1, 4'd2, 1);

        // back-to-back fmul
        repeat (6) step(1, c_fmul, 0, 4'd4, 4'd3, 1);
        step(0, 5'd0, 0, 4'd4, 4'd3, 1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 5'($urandom_range(0, 31)), ($urandom % 10) == 0,
                 4'($urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(0, 15)),
                 4'($urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(0, 15)),
                 ($urandom % 50) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
